// File: rtl/game_judge.sv
// game_judge
// Round referee downstream of the bomb engine and gadget logic. Every game
// tick the explosion map is sampled at both player tiles. Hits are charged
// against per-player lives, each hit is followed by an invulnerability
// window, and the round FSM steps through IDLE -> PLAY -> ROUND_END -> OVER.
//
// Ports:
//   clk          game tick clock (30 Hz domain)
//   rst          synchronous active-high reset
//   i_explode    256-bit flame map, bit n = tile n burning
//   p1_cor       player-1 tile index {y[3:0], x[3:0]}
//   p2_cor       player-2 tile index
//   i_start      start-round request, level-sensitive
//   o_p1_lives   player-1 remaining lives
//   o_p2_lives   player-2 remaining lives
//   o_p1_invuln  player-1 invulnerability active
//   o_p2_invuln  player-2 invulnerability active
//   o_freeze     upstream must ignore movement/bomb placement
//   o_game_over  round finished, result latched
//   o_winner     0 none, 1 player 1, 2 player 2, 3 draw
//   o_state      0 IDLE, 1 PLAY, 2 ROUND_END, 3 OVER
module game_judge #(
    parameter int unsigned LIVES           = 3,
    parameter int unsigned INVULN_TICKS    = 60,
    parameter int unsigned ROUND_END_DELAY = 90
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [255:0] i_explode,
    input  logic [7:0]   p1_cor,
    input  logic [7:0]   p2_cor,
    input  logic         i_start,
    output logic [2:0]   o_p1_lives,
    output logic [2:0]   o_p2_lives,
    output logic         o_p1_invuln,
    output logic         o_p2_invuln,
    output logic         o_freeze,
    output logic         o_game_over,
    output logic [1:0]   o_winner,
    output logic [1:0]   o_state
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PLAY      = 2'd1,
        ROUND_END = 2'd2,
        OVER      = 2'd3
    } state_t;

    localparam logic [2:0] LIVES_INIT = 3'(LIVES);
    localparam logic [7:0] INV_LOAD   = 8'(INVULN_TICKS);
    localparam logic [7:0] DELAY_LOAD = 8'(ROUND_END_DELAY);

    state_t     state;
    logic [2:0] p1_lives, p2_lives;
    logic [7:0] p1_inv, p2_inv;
    logic [7:0] delay_cnt;
    logic       freeze, game_over;
    logic [1:0] winner;

    logic       p1_hit, p2_hit;
    logic [2:0] p1_lives_nxt, p2_lives_nxt;

    // A hit needs flame on the tile, no active invulnerability and a life to
    // lose; the lives guard is what keeps the 3-bit count from underflowing.
    always_comb begin
        p1_hit       = i_explode[p1_cor] && (p1_inv == '0) && (p1_lives != '0);
        p2_hit       = i_explode[p2_cor] && (p2_inv == '0) && (p2_lives != '0);
        p1_lives_nxt = p1_hit ? (p1_lives - 3'd1) : p1_lives;
        p2_lives_nxt = p2_hit ? (p2_lives - 3'd1) : p2_lives;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            p1_lives  <= LIVES_INIT;
            p2_lives  <= LIVES_INIT;
            p1_inv    <= '0;
            p2_inv    <= '0;
            delay_cnt <= '0;
            freeze    <= 1'b1;
            game_over <= 1'b0;
            winner    <= 2'd0;
        end else begin
            // Invulnerability runs down in every state; a hit or a round
            // start below overrides this default.
            if (p1_inv != '0) p1_inv <= p1_inv - 8'd1;
            if (p2_inv != '0) p2_inv <= p2_inv - 8'd1;

            case (state)
                IDLE, OVER: begin
                    if (i_start) begin
                        state     <= PLAY;
                        p1_lives  <= LIVES_INIT;
                        p2_lives  <= LIVES_INIT;
                        p1_inv    <= '0;
                        p2_inv    <= '0;
                        winner    <= 2'd0;
                        freeze    <= 1'b0;
                        game_over <= 1'b0;
                    end
                end
                PLAY: begin
                    p1_lives <= p1_lives_nxt;
                    p2_lives <= p2_lives_nxt;
                    if (p1_hit) p1_inv <= INV_LOAD;
                    if (p2_hit) p2_inv <= INV_LOAD;
                    // Round ends on the same edge as the fatal decrement.
                    if ((p1_lives_nxt == '0) || (p2_lives_nxt == '0)) begin
                        state     <= ROUND_END;
                        delay_cnt <= DELAY_LOAD;
                        freeze    <= 1'b1;
                        if ((p1_lives_nxt == '0) && (p2_lives_nxt == '0))
                            winner <= 2'd3;
                        else if (p2_lives_nxt == '0)
                            winner <= 2'd1;
                        else
                            winner <= 2'd2;
                    end
                end
                ROUND_END: begin
                    if (delay_cnt == 8'd1) begin
                        state     <= OVER;
                        game_over <= 1'b1;
                    end else begin
                        delay_cnt <= delay_cnt - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_p1_lives  = p1_lives;
    assign o_p2_lives  = p2_lives;
    assign o_p1_invuln = (p1_inv != '0);
    assign o_p2_invuln = (p2_inv != '0);
    assign o_freeze    = freeze;
    assign o_game_over = game_over;
    assign o_winner    = winner;
    assign o_state     = state;

endmodule
